// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, FSM state encoding and illegal-opcode decode for the
// two-port ALU arbiter.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // 100 and 111 have no ALU function; the ALU drives X for them.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for both requesters of the ALU arbiter.
interface alu_arbiter_if;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_aluControl;
    logic [31:0] req0_srcA, req0_srcB;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_aluControl;
    logic [31:0] req1_srcA, req1_srcB;

    logic        resp0_valid, resp0_ready, resp0_zero, resp0_err;
    logic [31:0] resp0_result;
    logic        resp1_valid, resp1_ready, resp1_zero, resp1_err;
    logic [31:0] resp1_result;

    modport master (
        output req0_valid, req0_aluControl, req0_srcA, req0_srcB,
        output req1_valid, req1_aluControl, req1_srcA, req1_srcB,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_result, resp0_zero, resp0_err,
        input  resp1_valid, resp1_result, resp1_zero, resp1_err,
        output resp0_ready, resp1_ready
    );

    modport slave (
        input  req0_valid, req0_aluControl, req0_srcA, req0_srcB,
        input  req1_valid, req1_aluControl, req1_srcA, req1_srcB,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_result, resp0_zero, resp0_err,
        output resp1_valid, resp1_result, resp1_zero, resp1_err,
        input  resp0_ready, resp1_ready
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Existing combinational ALU with 3-bit control; unknown opcodes produce X,
// which callers must mask.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0]  aluControl,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        case (aluControl)
            OP_ADD:  result = srcA + srcB;
            OP_SUB:  result = srcA - srcB;
            OP_AND:  result = srcA & srcB;
            OP_OR:   result = srcA | srcB;
            OP_SLT:  result = {31'b0, srcA < srcB};
            OP_SRA:  result = $unsigned($signed(srcA) >>> srcB[4:0]);
            default: result = 'x;
        endcase
    end

    assign zero = (result == 32'd0);
endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU with a single op in flight (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin grant; otherwise port 0 has fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic         busy
);
    state_t      r_state, w_next;
    logic        r_own;
    logic [2:0]  r_op;
    logic [31:0] r_src_a, r_src_b, r_result;
    logic        r_zero, r_err;
    logic        w_grant, w_any, w_accept, w_illegal, w_idle, w_resp, w_resp_rdy;
    logic        w_alu_zero;
    logic [31:0] w_alu_result;

`ifdef ALU_ARB_RR_EN
    // Pointer names the port preferred on the next contended grant.
    logic r_rr_ptr;
    always_ff @(posedge clk) begin
        if (!rst_n)        r_rr_ptr <= 1'b0;
        else if (w_accept) r_rr_ptr <= ~w_grant;
    end
    assign w_grant = (bus.req0_valid && bus.req1_valid) ? r_rr_ptr : !bus.req0_valid;
`else
    assign w_grant = !bus.req0_valid;
`endif

    assign w_any      = bus.req0_valid | bus.req1_valid;
    assign w_resp_rdy = r_own ? bus.resp1_ready : bus.resp0_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: if (w_any) begin
                w_next   = ST_EXEC;
                w_accept = 1'b1;
            end
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (w_resp_rdy) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_own    <= 1'b0;
            r_op     <= '0;
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_own   <= w_grant;
                r_op    <= w_grant ? bus.req1_aluControl : bus.req0_aluControl;
                r_src_a <= w_grant ? bus.req1_srcA : bus.req0_srcA;
                r_src_b <= w_grant ? bus.req1_srcB : bus.req0_srcB;
            end
            // Illegal opcodes are masked here so the ALU's X never reaches a port.
            if (r_state == ST_EXEC) begin
                r_err    <= w_illegal;
                r_result <= w_illegal ? '0 : w_alu_result;
                r_zero   <= !w_illegal && w_alu_zero;
            end
        end
    end

    assign w_illegal = is_illegal_op(r_op);

    alu_arbiter_alu u_alu (
        .aluControl (r_op),
        .srcA       (r_src_a),
        .srcB       (r_src_b),
        .result     (w_alu_result),
        .zero       (w_alu_zero)
    );

    assign w_idle = rst_n && (r_state == ST_IDLE);
    assign w_resp = rst_n && (r_state == ST_RESP);
    assign busy   = rst_n && (r_state != ST_IDLE);

    assign bus.req0_ready   = w_idle && bus.req0_valid && !w_grant;
    assign bus.req1_ready   = w_idle && bus.req1_valid && w_grant;

    assign bus.resp0_valid  = w_resp && !r_own;
    assign bus.resp0_result = (w_resp && !r_own) ? r_result : '0;
    assign bus.resp0_zero   = w_resp && !r_own && r_zero;
    assign bus.resp0_err    = w_resp && !r_own && r_err;
    assign bus.resp1_valid  = w_resp && r_own;
    assign bus.resp1_result = (w_resp && r_own) ? r_result : '0;
    assign bus.resp1_zero   = w_resp && r_own && r_zero;
    assign bus.resp1_err    = w_resp && r_own && r_err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: randomized and directed requests against a
// behavioural ALU/arbitration model; a separate monitor checks every response.
module tb_alu_arbiter;
    logic clk, rst_n, busy;
    alu_arbiter_if bus();

    alu_arbiter u_dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } req_t;
    typedef struct { int port; logic [31:0] res; logic zero; logic err; } exp_t;

    req_t rq0[$], rq1[$];
    exp_t sb[$];
    int   glog[$];

    int          checks = 0, passes = 0, cyc = 0;
    bit          pend[2];
    req_t        cur[2];
    bit          outstanding = 0;
    int          own = 0, acc_cyc = 0, last_grant = 1;
    int          mode = 1;   // 0 random resp_ready, 1 always ready, 2 owner stalls 5 cycles

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        chk(name, {31'b0, act}, {31'b0, expv});
    endtask

    // Spec-level ALU: {err, zero, result}
    function automatic logic [33:0] ref_alu(input req_t r);
        logic [31:0] v;
        case (r.op)
            3'd0: v = r.a + r.b;
            3'd1: v = r.a - r.b;
            3'd2: v = r.a & r.b;
            3'd3: v = r.a | r.b;
            3'd5: v = (r.a < r.b) ? 32'd1 : 32'd0;
            3'd6: begin
                v = r.a >> r.b[4:0];
                if (r.a[31]) v = v | ~(32'hFFFF_FFFF >> r.b[4:0]);
            end
            default: return {1'b1, 1'b0, 32'd0};
        endcase
        return {1'b0, (v == 32'd0), v};
    endfunction

    task automatic drive_bus();
        bus.req0_valid = pend[0]; bus.req0_aluControl = cur[0].op;
        bus.req0_srcA  = cur[0].a; bus.req0_srcB = cur[0].b;
        bus.req1_valid = pend[1]; bus.req1_aluControl = cur[1].op;
        bus.req1_srcA  = cur[1].a; bus.req1_srcB = cur[1].b;
    endtask

    // Driver + arbitration model: checks handshake outputs each cycle, drives inputs after the edge.
    always begin : p_drv
        int n, g;
        bit acc, hs, rv, do_rst;
        exp_t e;
        logic [33:0] m;
        @(negedge clk);
        n = cyc; acc = 0; hs = 0; g = 0;
        if (!rst_n) begin
            do_rst = 1;
            chk1("rst_req0_ready", bus.req0_ready, 1'b0);
            chk1("rst_req1_ready", bus.req1_ready, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_resp0_valid", bus.resp0_valid, 1'b0);
            chk1("rst_resp1_valid", bus.resp1_valid, 1'b0);
            chk("rst_resp_result_or", bus.resp0_result | bus.resp1_result, 32'd0);
        end else begin
            do_rst = 0;
            if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_RR_EN
                g = (last_grant == 0) ? 1 : 0;
`else
                g = 0;
`endif
            end else g = pend[0] ? 0 : 1;
            acc = !outstanding && (pend[0] || pend[1]);
            chk1("req0_ready", bus.req0_ready, acc && g == 0);
            chk1("req1_ready", bus.req1_ready, acc && g == 1);
            chk1("busy", busy, outstanding);
            rv = outstanding && (n >= acc_cyc + 2);
            chk1("resp0_valid", bus.resp0_valid, rv && own == 0);
            chk1("resp1_valid", bus.resp1_valid, rv && own == 1);
            hs = rv && ((own == 0) ? bus.resp0_ready : bus.resp1_ready);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (do_rst) begin
            outstanding = 0; last_grant = 1; sb.delete(); glog.delete();
        end else begin
            if (acc) begin
                m = ref_alu(cur[g]);
                e.port = g; e.err = m[33]; e.zero = m[32]; e.res = m[31:0];
                sb.push_back(e);
                glog.push_back(g);
                own = g; acc_cyc = n; outstanding = 1; last_grant = g; pend[g] = 0;
            end
            if (hs) outstanding = 0;
        end
        if (!pend[0] && rq0.size() > 0) begin cur[0] = rq0.pop_front(); pend[0] = 1; end
        if (!pend[1] && rq1.size() > 0) begin cur[1] = rq1.pop_front(); pend[1] = 1; end
        drive_bus();
        case (mode)
            0: begin
                bus.resp0_ready = 1'($urandom_range(0, 1));
                bus.resp1_ready = 1'($urandom_range(0, 1));
            end
            2: begin
                bus.resp0_ready = !(outstanding && own == 0 && cyc < acc_cyc + 7);
                bus.resp1_ready = !(outstanding && own == 1 && cyc < acc_cyc + 7);
            end
            default: begin bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1; end
        endcase
    end

    // Monitor: compares presented responses against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.resp0_valid || bus.resp1_valid)) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: valid0=%b valid1=%b with nothing expected (cycle %0d)",
                         bus.resp0_valid, bus.resp1_valid, cyc);
            end else begin
                e = sb[0];
                if (e.port == 0) begin
                    chk("resp0_result", bus.resp0_result, e.res);
                    chk1("resp0_zero", bus.resp0_zero, e.zero);
                    chk1("resp0_err", bus.resp0_err, e.err);
                    chk("resp1_idle_fields", {bus.resp1_result[31:2], bus.resp1_result[1:0] | {bus.resp1_zero, bus.resp1_err}}, 32'd0);
                    if (bus.resp0_ready) void'(sb.pop_front());
                end else begin
                    chk("resp1_result", bus.resp1_result, e.res);
                    chk1("resp1_zero", bus.resp1_zero, e.zero);
                    chk1("resp1_err", bus.resp1_err, e.err);
                    chk("resp0_idle_fields", {bus.resp0_result[31:2], bus.resp0_result[1:0] | {bus.resp0_zero, bus.resp0_err}}, 32'd0);
                    if (bus.resp1_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b;
        if (port == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || pend[0] || pend[1] || outstanding) && n < budget) begin
            step();
            n++;
        end
        if (rq0.size() > 0 || rq1.size() > 0 || pend[0] || pend[1] || outstanding) begin
            checks++;
            $display("FAIL wait_idle: still busy after %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    initial begin
        int grant_exp[4];
        int n;
        logic [31:0] a, b;
        rst_n = 1'b0;
        pend[0] = 0; pend[1] = 0;
        cur[0] = '{3'd0, 32'd0, 32'd0}; cur[1] = '{3'd0, 32'd0, 32'd0};
        drive_bus();
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;

        // Both ports valid through and after reset: first four grants
        for (int i = 0; i < 4; i++) begin
            push(0, 3'b000, 32'(i), 32'd100);
            push(1, 3'b001, 32'(i), 32'd1);
        end
        repeat (3) step();
        rst_n = 1'b1;
        wait_idle(200);
`ifdef ALU_ARB_RR_EN
        grant_exp = '{0, 1, 0, 1};
`else
        grant_exp = '{0, 0, 0, 0};
`endif
        chk("grant_log_size_ge4", {31'b0, glog.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < glog.size()) chk($sformatf("grant_%0d", i), 32'(glog[i]), 32'(grant_exp[i]));

        push(0, 3'b000, 32'd5, 32'd7);            // add -> 12
        wait_idle(50);
        push(1, 3'b001, 32'd9, 32'd9);            // sub -> 0, zero
        wait_idle(50);

        mode = 2;                                 // owner holds resp_ready low 5 cycles
        push(0, 3'b011, 32'h0F00_0000, 32'h0000_00F0);
        wait_idle(50);
        mode = 1;

        push(0, 3'b100, 32'h1234_5678, 32'h0);    // illegal
        push(0, 3'b101, 32'd3, 32'hFFFF_FFFF);    // unsigned slt -> 1
        push(1, 3'b111, 32'd0, 32'd0);            // illegal with zero operands
        push(1, 3'b110, 32'h8000_0000, 32'd4);    // sra sign fill
        wait_idle(100);

        // Reset pulse while the op is in EXEC
        push(0, 3'b000, 32'd1, 32'd2);
        n = 0;
        while (!(outstanding && cyc == acc_cyc + 1) && n < 20) begin step(); n++; end
        chk1("reached_exec", outstanding && cyc == acc_cyc + 1, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        push(1, 3'b001, 32'd10, 32'd3);
        wait_idle(50);

        // Randomized bursts with random response back-pressure
        mode = 0;
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
                push(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, b);
            end
            repeat ($urandom_range(0, 8)) step();
        end
        wait_idle(5000);
        mode = 1;
        repeat (3) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have ports, per requester k in {0,1}: reqK_valid in 1; reqK_ready out 1; reqK_aluControl in 3; reqK_srcA in 32; reqK_srcB in 32.
REQ-004 SHALL have ports, per requester k: respK_valid out 1; respK_ready in 1; respK_result out 32; respK_zero out 1; respK_err out 1.
REQ-005 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-006 SHALL share one ALU instance between the two requesters, with at most one operation in flight.
REQ-007 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-008 IDLE: reqK_ready = 1 only for the granted port; all other ready outputs = 0.
REQ-009 IDLE: if any reqK_valid, grant one port per REQ-019; operands, opcode and owner are registered and the FSM moves to EXEC.
REQ-010 EXEC: registered operands drive the ALU; result, zero and err are registered and the FSM moves to RESP after exactly 1 cycle.
REQ-011 RESP: respK_valid = 1 for the owner only; result, zero and err stay stable until respK_ready = 1, then the FSM returns to IDLE.
REQ-012 Latency: request accepted at edge N gives resp_valid high from cycle N+2; best throughput is 1 operation per 3 cycles.
REQ-013 Opcodes: 000 add; 001 sub; 010 and; 011 or; 101 unsigned slt (result 1/0); 110 sra.
REQ-014 All adds and subtracts SHALL be modulo 2^32 with no overflow flag.
REQ-015 Opcodes 100 and 111 are illegal: result = 0, zero = 0, err = 1; the X output of the ALU SHALL never reach a port.
REQ-016 respK_zero SHALL be 1 iff a legal result equals 0.
REQ-017 Non-owner respK_valid, result, zero and err SHALL be 0.
REQ-018 reqK_valid changing during EXEC or RESP SHALL be ignored; no request is queued.
REQ-019 Grant: with one valid requester, that port wins; with both valid, the winner is set by the macro (REQ-024/025).

Reset
REQ-020 While rst_n = 0: state = IDLE; busy = 0; all ready/valid/result/zero/err outputs = 0; RR pointer = port 0 preferred.
REQ-021 Reset asserted in EXEC or RESP SHALL abort the operation; no response is issued after reset releases.
REQ-022 The first grant after reset with both ports valid SHALL go to port 0.

Configuration
REQ-023 Macro ALU_ARB_RR_EN SHALL select the arbitration policy.
REQ-024 With ALU_ARB_RR_EN defined: round-robin; the pointer toggles to the other port on each accept; when both ports are valid, the non-last-granted port wins.
REQ-025 Without ALU_ARB_RR_EN: fixed priority, port 0 always wins; no pointer register exists.

Structure
REQ-026 A shared package SHALL hold the 3-bit opcode constants (ADD, SUB, AND, OR, SLT, SRA), the FSM state enum and the illegal-opcode decode.
REQ-027 One sub-module SHALL exist: ALU (the team's existing combinational 3-bit-control ALU), instantiated once.
REQ-028 The illegal-opcode masking SHALL be implemented in alu_arbiter, not in ALU.

Verification
REQ-029 Port 0 sends add 5+7 at edge N -> resp0_valid at N+2, result 12, zero 0, err 0.
REQ-030 Port 1 sends sub 9-9 -> resp1_result 0, resp1_zero 1; resp0_valid stays 0.
REQ-031 Both ports hold valid for 4 ops after reset, with RR_EN -> grants 0,1,0,1; without RR_EN -> grants 0,0,0,0.
REQ-032 resp0_ready held low 5 cycles in RESP -> result, zero and valid stable; busy 1; req ready signals 0; IDLE follows the cycle after resp0_ready = 1.
REQ-033 Opcode 3'b100 -> result 0, zero 0, err 1; then slt 3<0xFFFFFFFF -> result 1.
REQ-034 rst_n low for 1 cycle during EXEC -> no resp_valid afterwards; the next request is serviced normally.
